// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: register addresses and FSM states.
package irq_pkg;

    localparam logic [1:0] IRQ_MASK  = 2'd0;
    localparam logic [1:0] IRQ_MODE  = 2'd1;
    localparam logic [1:0] IRQ_PEND  = 2'd2;
    localparam logic [1:0] IRQ_INSVC = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt input: multi-flop synchroniser followed by a registered level and
// a registered one-cycle rise pulse, both aligned to the same clock edge.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q;
    logic                   rise_q;

    // Registering rise alongside level keeps edge and level channels at equal latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], irq_i};
            level_q <= sync_q[SYNC_STAGES-1];
            rise_q  <= sync_q[SYNC_STAGES-1] & ~level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller: per-channel sync, edge/level pending, mask,
// single-request ack/eoi handshake to the CPU and a small config register port.
module interrupt_controller
    import irq_pkg::*;
#(
    parameter  int CHANNELS    = 8,
    parameter  int SYNC_STAGES = 2,
    localparam int ID_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] irq_in,
    output logic                int_req,
    output logic [ID_W-1:0]     int_id,
    input  logic                int_ack,
    input  logic                int_eoi,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_addr,
    input  logic [CHANNELS-1:0] cfg_wdata,
    output logic [CHANNELS-1:0] cfg_rdata
);

    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] rise;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_sync
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk    (clk),
            .reset  (reset),
            .irq_i  (irq_in[g]),
            .level_o(level[g]),
            .rise_o (rise[g])
        );
    end

    // Lowest set index wins.
    function automatic logic [ID_W-1:0] prio_enc(input logic [CHANNELS-1:0] v);
        logic [ID_W-1:0] r;
        r = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (v[i]) r = ID_W'(i);
        end
        return r;
    endfunction

    irq_state_e          state_q, state_d;
    logic                req_q, req_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [CHANNELS-1:0] mask_q, mask_d;
    logic [CHANNELS-1:0] mode_q, mode_d;
    logic [CHANNELS-1:0] pend_q, pend_d;
    logic [CHANNELS-1:0] insvc_q, insvc_d;
    logic [CHANNELS-1:0] rdata_q, rdata_d;

    logic [CHANNELS-1:0] req_vec;
    logic [CHANNELS-1:0] id_onehot;
    logic [CHANNELS-1:0] clr;
    logic                ack_go;

    always_comb begin
        req_vec   = pend_q & mask_q;
        id_onehot = CHANNELS'(1) << id_q;
        ack_go    = (state_q == REQ) && int_ack;

        clr = '0;
        if (cfg_we && cfg_addr == IRQ_PEND) clr = clr | cfg_wdata;
        if (ack_go)                         clr = clr | id_onehot;

        // A rise in the same cycle as a clear must leave the channel pending.
        pend_d = (mode_q & ((pend_q & ~clr) | rise)) | (~mode_q & level);
        mask_d = (cfg_we && cfg_addr == IRQ_MASK) ? cfg_wdata : mask_q;
        mode_d = (cfg_we && cfg_addr == IRQ_MODE) ? cfg_wdata : mode_q;

        state_d = state_q;
        req_d   = req_q;
        id_d    = id_q;
        insvc_d = insvc_q;

        case (state_q)
            IDLE: begin
                if (req_vec != '0) begin
                    id_d    = prio_enc(req_vec);
                    req_d   = 1'b1;
                    state_d = REQ;
                end else begin
                    req_d = 1'b0;
                end
            end
            REQ: begin
                if (int_ack) begin
                    insvc_d = id_onehot;
                    req_d   = 1'b0;
                    state_d = SERVICE;
                end else if (req_vec == '0) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    id_d = prio_enc(req_vec);
                end
            end
            SERVICE: begin
                if (int_eoi) begin
                    insvc_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Readback reflects the contents after this cycle's write.
        case (cfg_addr)
            IRQ_MASK: rdata_d = mask_d;
            IRQ_MODE: rdata_d = mode_d;
            IRQ_PEND: rdata_d = pend_d;
            default:  rdata_d = insvc_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            id_q    <= '0;
            mask_q  <= '0;
            mode_q  <= '1;
            pend_q  <= '0;
            insvc_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            id_q    <= id_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            insvc_q <= insvc_d;
            rdata_q <= rdata_d;
        end
    end

    assign int_req   = req_q;
    assign int_id    = id_q;
    assign cfg_rdata = rdata_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a delay-line behavioural model.
module tb_interrupt_controller;

    localparam int CH = 8;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] irq_in;
    logic          int_req;
    logic [2:0]    int_id;
    logic          int_ack;
    logic          int_eoi;
    logic          cfg_we;
    logic [1:0]    cfg_addr;
    logic [CH-1:0] cfg_wdata;
    logic [CH-1:0] cfg_rdata;

    always #5 clk = ~clk;

    interrupt_controller #(
        .CHANNELS   (CH),
        .SYNC_STAGES(SS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .irq_in   (irq_in),
        .int_req  (int_req),
        .int_id   (int_id),
        .int_ack  (int_ack),
        .int_eoi  (int_eoi),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata)
    );

    int nTests = 0;
    int nFail  = 0;
    bit checkEn = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the synchronised input is simply irq_in delayed by SS+1 edges.
    logic [CH-1:0] hist [0:SS+1];
    logic [CH-1:0] mPend, mMask, mMode, mInsvc, mRdata;
    int            mState;
    bit            mReq;
    int            mId;

    function automatic int lowestSet(input logic [CH-1:0] v);
        for (int i = 0; i < CH; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge clk) begin : model
        logic [CH-1:0] lvl, rs, clr, vec, newPend, newMask, newMode, newInsvc;
        if (reset) begin
            for (int j = 0; j <= SS + 1; j++) hist[j] = '0;
            mPend = '0; mMask = '0; mMode = '1; mInsvc = '0; mRdata = '0;
            mState = 0; mReq = 1'b0; mId = 0;
        end else begin
            lvl = hist[SS];
            rs  = hist[SS] & ~hist[SS+1];
            vec = mPend & mMask;
            clr = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata : '0;
            newInsvc = mInsvc;
            case (mState)
                0: if (vec != 0) begin mId = lowestSet(vec); mReq = 1'b1; mState = 1; end
                1: begin
                    if (int_ack) begin
                        clr[mId] = 1'b1;
                        newInsvc = '0;
                        newInsvc[mId] = 1'b1;
                        mReq = 1'b0;
                        mState = 2;
                    end else if (vec == 0) begin
                        mReq = 1'b0;
                        mState = 0;
                    end else begin
                        mId = lowestSet(vec);
                    end
                end
                default: if (int_eoi) begin newInsvc = '0; mState = 0; end
            endcase
            for (int i = 0; i < CH; i++)
                newPend[i] = mMode[i] ? ((mPend[i] && !clr[i]) || rs[i]) : lvl[i];
            newMask = (cfg_we && cfg_addr == 2'd0) ? cfg_wdata : mMask;
            newMode = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata : mMode;
            mPend = newPend; mMask = newMask; mMode = newMode; mInsvc = newInsvc;
            case (cfg_addr)
                2'd0:    mRdata = mMask;
                2'd1:    mRdata = mMode;
                2'd2:    mRdata = mPend;
                default: mRdata = mInsvc;
            endcase
            for (int j = SS + 1; j >= 1; j--) hist[j] = hist[j-1];
            hist[0] = irq_in;
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            cmp("model_int_req", 32'(int_req), 32'(mReq));
            cmp("model_int_id", 32'(int_id), 32'(mId));
            cmp("model_cfg_rdata", 32'(cfg_rdata), 32'(mRdata));
        end
    end

    task automatic applyStimulus(input logic [CH-1:0] irq, input bit ack, input bit eoi,
                                 input bit we, input logic [1:0] addr, input logic [CH-1:0] wdata);
        irq_in    = irq;
        int_ack   = ack;
        int_eoi   = eoi;
        cfg_we    = we;
        cfg_addr  = addr;
        cfg_wdata = wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input bit req, input int id, input logic [CH-1:0] rdata);
        cmp({name, "_req"}, 32'(int_req), 32'(req));
        cmp({name, "_id"}, 32'(int_id), 32'(id));
        cmp({name, "_rdata"}, 32'(cfg_rdata), 32'(rdata));
    endtask

    task automatic idle(input int n, input logic [CH-1:0] irq, input logic [1:0] addr);
        for (int k = 0; k < n; k++) applyStimulus(irq, 1'b0, 1'b0, 1'b0, addr, '0);
    endtask

    logic [CH-1:0] irqR;

    initial begin
        reset = 1'b1;
        applyStimulus('0, 0, 0, 0, 2'd0, '0);
        checkEn = 1'b1;
        checkOutput("reset", 0, 0, 8'h00);
        reset = 1'b0;

        // Single edge pulse on channel 3, request at edge 4.
        applyStimulus('0, 0, 0, 1, 2'd0, 8'hFF);   checkOutput("mask_wr", 0, 0, 8'hFF);
        applyStimulus(8'h08, 0, 0, 0, 2'd2, '0);
        idle(3, '0, 2'd2);                         checkOutput("t1_pend", 0, 0, 8'h08);
        idle(1, '0, 2'd2);                         checkOutput("t1_req", 1, 3, 8'h08);
        applyStimulus('0, 1, 0, 0, 2'd2, '0);      checkOutput("t1_ack", 0, 3, 8'h00);
        applyStimulus('0, 0, 0, 0, 2'd3, '0);      checkOutput("t1_insvc", 0, 3, 8'h08);
        applyStimulus('0, 0, 1, 0, 2'd3, '0);      checkOutput("t1_eoi", 0, 3, 8'h00);

        // Channels 5 and 2 together: 2 first, then 5.
        applyStimulus(8'h24, 0, 0, 0, 2'd2, '0);
        idle(3, '0, 2'd2);                         checkOutput("t2_pend", 0, 3, 8'h24);
        idle(1, '0, 2'd2);                         checkOutput("t2_req2", 1, 2, 8'h24);
        applyStimulus('0, 1, 0, 0, 2'd2, '0);      checkOutput("t2_ack2", 0, 2, 8'h20);
        applyStimulus('0, 0, 1, 0, 2'd3, '0);      checkOutput("t2_eoi2", 0, 2, 8'h00);
        idle(1, '0, 2'd2);                         checkOutput("t2_req5", 1, 5, 8'h20);
        applyStimulus('0, 1, 0, 0, 2'd2, '0);      checkOutput("t2_ack5", 0, 5, 8'h00);
        applyStimulus('0, 0, 1, 0, 2'd3, '0);

        // Masked pending, unmask, then W1C while requesting.
        applyStimulus('0, 0, 0, 1, 2'd0, 8'h00);   checkOutput("t3_mask0", 0, 5, 8'h00);
        applyStimulus(8'h02, 0, 0, 0, 2'd2, '0);
        idle(4, '0, 2'd2);                         checkOutput("t3_masked", 0, 5, 8'h02);
        applyStimulus('0, 0, 0, 1, 2'd0, 8'h02);   checkOutput("t3_unmask", 0, 5, 8'h02);
        idle(1, '0, 2'd2);                         checkOutput("t3_req", 1, 1, 8'h02);
        applyStimulus('0, 0, 0, 1, 2'd2, 8'h02);   checkOutput("t3_w1c", 1, 1, 8'h00);
        idle(1, '0, 2'd2);                         checkOutput("t3_drop", 0, 1, 8'h00);

        // Level channel 0 held high re-requests after eoi; releasing it drops the request.
        applyStimulus('0, 0, 0, 1, 2'd0, 8'hFF);   checkOutput("t4_mask", 0, 1, 8'hFF);
        applyStimulus('0, 0, 0, 1, 2'd1, 8'hFE);   checkOutput("t4_mode", 0, 1, 8'hFE);
        idle(4, 8'h01, 2'd2);                      checkOutput("t4_pend", 0, 1, 8'h01);
        idle(1, 8'h01, 2'd2);                      checkOutput("t4_req", 1, 0, 8'h01);
        applyStimulus(8'h01, 1, 0, 0, 2'd2, '0);   checkOutput("t4_ack", 0, 0, 8'h01);
        applyStimulus(8'h01, 0, 1, 0, 2'd3, '0);   checkOutput("t4_eoi", 0, 0, 8'h00);
        idle(1, 8'h01, 2'd2);                      checkOutput("t4_rereq", 1, 0, 8'h01);
        idle(4, '0, 2'd2);                         checkOutput("t4_fall", 1, 0, 8'h00);
        idle(1, '0, 2'd2);                         checkOutput("t4_noreq", 0, 0, 8'h00);
        applyStimulus('0, 0, 0, 1, 2'd1, 8'hFF);   checkOutput("t4_mode_rst", 0, 0, 8'hFF);

        // Channel 4: edge during service, then rise coincident with ack clear.
        applyStimulus(8'h10, 0, 0, 0, 2'd2, '0);
        idle(4, '0, 2'd2);                         checkOutput("t5_req", 1, 4, 8'h10);
        applyStimulus('0, 1, 0, 0, 2'd2, '0);      checkOutput("t5_ack", 0, 4, 8'h00);
        applyStimulus(8'h10, 0, 0, 0, 2'd2, '0);
        idle(3, '0, 2'd2);                         checkOutput("t5_svcpend", 0, 4, 8'h10);
        applyStimulus('0, 0, 1, 0, 2'd2, '0);      checkOutput("t5_eoi", 0, 4, 8'h10);
        idle(1, '0, 2'd2);                         checkOutput("t5_rereq", 1, 4, 8'h10);
        applyStimulus(8'h10, 0, 0, 0, 2'd2, '0);
        idle(2, '0, 2'd2);
        applyStimulus('0, 1, 0, 0, 2'd2, '0);      checkOutput("t5_setwins", 0, 4, 8'h10);
        applyStimulus('0, 0, 1, 0, 2'd3, '0);
        idle(1, '0, 2'd2);                         checkOutput("t5_again", 1, 4, 8'h10);
        applyStimulus('0, 1, 0, 0, 2'd2, '0);
        applyStimulus('0, 0, 1, 0, 2'd3, '0);

        // Reset while in SERVICE with everything pending.
        applyStimulus(8'h40, 0, 0, 0, 2'd2, '0);
        idle(4, '0, 2'd2);                         checkOutput("t6_req", 1, 6, 8'h40);
        applyStimulus('0, 1, 0, 0, 2'd2, '0);
        applyStimulus(8'hFF, 0, 0, 0, 2'd2, '0);
        idle(3, '0, 2'd2);                         checkOutput("t6_allpend", 0, 6, 8'hFF);
        reset = 1'b1;
        applyStimulus('0, 0, 0, 0, 2'd0, '0);      checkOutput("t6_reset", 0, 0, 8'h00);
        reset = 1'b0;
        applyStimulus('0, 0, 0, 0, 2'd0, '0);      checkOutput("t6_mask", 0, 0, 8'h00);
        applyStimulus('0, 0, 0, 0, 2'd1, '0);      checkOutput("t6_mode", 0, 0, 8'hFF);
        applyStimulus('0, 0, 0, 0, 2'd2, '0);      checkOutput("t6_pend", 0, 0, 8'h00);
        applyStimulus('0, 0, 0, 0, 2'd3, '0);      checkOutput("t6_insvc", 0, 0, 8'h00);

        // Randomized traffic; the model compare process does the checking.
        irqR = '0;
        for (int c = 0; c < 4000; c++) begin
            irqR  = irqR ^ CH'($urandom & $urandom & $urandom);
            reset = ($urandom_range(0, 299) == 0);
            applyStimulus(irqR,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 9) == 0,
                          2'($urandom_range(0, 3)),
                          CH'($urandom));
            reset = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
